// File: rtl/pwlcm_keystream_ctrl_if.sv
// Bundle of config, map-core and keystream signals around the
// PWLCM keystream controller.
interface pwlcm_keystream_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_x0;
  logic [30:0] cfg_p;
  logic [15:0] cfg_nwords;
  logic [31:0] map_xp;
  logic [30:0] map_pp;
  logic        map_start;
  logic [31:0] map_xpn;
  logic        map_done;
  logic [31:0] ks_data;
  logic        ks_valid;
  logic        ks_ready;
  logic        busy;
  logic        err_cfg;
  logic        err_timeout;
  logic        err_stuck;

  modport master (
    input  cfg_valid, cfg_x0, cfg_p, cfg_nwords,
    input  map_xpn, map_done, ks_ready,
    output cfg_ready, map_xp, map_pp, map_start,
    output ks_data, ks_valid, busy,
    output err_cfg, err_timeout, err_stuck
  );

  modport slave (
    output cfg_valid, cfg_x0, cfg_p, cfg_nwords,
    output map_xpn, map_done, ks_ready,
    input  cfg_ready, map_xp, map_pp, map_start,
    input  ks_data, ks_valid, busy,
    input  err_cfg, err_timeout, err_stuck
  );
endinterface

// File: rtl/pwlcm_keystream_ctrl.sv
// PWLCM keystream controller: seeds the map core, discards warm-up
// iterations, then streams each new state out as a keystream word.
module pwlcm_keystream_ctrl #(
  parameter int WARMUP     = 64,
  parameter int TIMEOUT    = 256,
  parameter int DONE_BLANK = 2
) (
  input logic clk,
  input logic rst,
  pwlcm_keystream_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_EMIT
  } state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_xp, r_ks_data;
  logic [30:0]   r_pp;
  logic [15:0]   r_rem, r_warm;
  logic [CW-1:0] r_cnt;
  logic          r_ks_valid;
  logic          r_err_cfg, r_err_to, r_err_stuck;
  logic          w_cfg_bad, w_cfg_go;
  logic          w_done_acc, w_tmo, w_stuck, w_ks_fire;

  assign w_cfg_bad = (bus.cfg_x0 == '0) || (bus.cfg_p == '0);
  assign w_cfg_go  = bus.cfg_valid && !w_cfg_bad
                  && (bus.cfg_nwords != '0);
  // done level may linger from the previous result; blank it out
  assign w_done_acc = (r_state == S_WAIT) && bus.map_done
                   && (r_cnt >= CW'(DONE_BLANK));
  assign w_tmo = (r_state == S_WAIT) && !w_done_acc
              && (r_cnt == CW'(TIMEOUT - 1));
  assign w_stuck   = w_done_acc && (bus.map_xpn == r_xp);
  assign w_ks_fire = (r_state == S_EMIT) && bus.ks_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cfg_go) w_next = S_SETUP;
      S_SETUP: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (w_stuck || w_tmo)
          w_next = S_IDLE;
        else if (w_done_acc)
          w_next = (r_warm != '0) ? S_SETUP : S_EMIT;
      end
      S_EMIT: begin
        if (w_ks_fire)
          w_next = (r_rem == 16'd1) ? S_IDLE : S_SETUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_xp        <= '0;
      r_pp        <= '0;
      r_rem       <= '0;
      r_warm      <= '0;
      r_cnt       <= '0;
      r_ks_data   <= '0;
      r_ks_valid  <= 1'b0;
      r_err_cfg   <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_stuck <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            r_err_cfg   <= w_cfg_bad;
            r_err_to    <= 1'b0;
            r_err_stuck <= 1'b0;
            r_xp        <= bus.cfg_x0;
            r_pp        <= bus.cfg_p;
            r_rem       <= bus.cfg_nwords;
            r_warm      <= 16'(WARMUP);
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (w_stuck) begin
            r_err_stuck <= 1'b1;
          end else if (w_done_acc) begin
            r_xp <= bus.map_xpn;
            if (r_warm != '0) begin
              r_warm <= r_warm - 16'd1;
            end else begin
              r_ks_data  <= bus.map_xpn;
              r_ks_valid <= 1'b1;
            end
          end else if (w_tmo) begin
            r_err_to <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_ks_fire) begin
            r_ks_valid <= 1'b0;
            r_rem      <= r_rem - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.map_start   = (r_state == S_START);
  assign bus.map_xp      = r_xp;
  assign bus.map_pp      = r_pp;
  assign bus.ks_data     = r_ks_data;
  assign bus.ks_valid    = r_ks_valid;
  assign bus.err_cfg     = r_err_cfg;
  assign bus.err_timeout = r_err_to;
  assign bus.err_stuck   = r_err_stuck;
endmodule

// File: tb/tb_pwlcm_keystream_ctrl.sv
// Bench for pwlcm_keystream_ctrl: behavioural PWLCM map core plus
// a reference sequence computed straight from the map definition.
module tb_pwlcm_keystream_ctrl;
  localparam int L_MAP = 40;
  localparam int TMO   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwlcm_keystream_ctrl_if if0 ();
  pwlcm_keystream_ctrl_if if1 ();

  pwlcm_keystream_ctrl #(.WARMUP(0), .TIMEOUT(TMO),
                         .DONE_BLANK(2))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  pwlcm_keystream_ctrl #(.WARMUP(64), .TIMEOUT(TMO),
                         .DONE_BLANK(2))
    u64 (.clk(clk), .rst(rst), .bus(if1));

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // x -> x/p, (x-p)/(0.5-p), mirrored above 0.5; Q0.32 fixed point
  function automatic logic [31:0] pwlcm(input logic [31:0] x,
                                        input logic [30:0] p);
    longint unsigned xx, pp, r;
    xx = 64'(x);
    pp = 64'(p);
    if (pp == 0) return x;
    if (xx >= 64'h8000_0000) xx = 64'h1_0000_0000 - xx;
    if (xx < pp)
      r = (xx << 32) / pp;
    else if (xx < 64'h8000_0000)
      r = ((xx - pp) << 32) / (64'h8000_0000 - pp);
    else
      r = 64'hFFFF_FFFF;
    if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  // map core model for u0, with knobs for fault scenarios
  logic        m0_pend = 1'b0;
  int          m0_cnt = 0, m0_hold = 0, m0_hlen = 3;
  logic [31:0] m0_x = '0, m0_xpn = '0;
  logic [30:0] m0_p = '0;
  bit          m0_mute = 1'b0, m0_stuck = 1'b0;

  always @(posedge clk) begin
    if (m0_hold > 0) m0_hold <= m0_hold - 1;
    if (if0.map_start) begin
      m0_pend <= 1'b1;
      m0_cnt  <= L_MAP;
      m0_x    <= if0.map_xp;
      m0_p    <= if0.map_pp;
    end else if (m0_pend) begin
      if (m0_cnt == 1) begin
        m0_pend <= 1'b0;
        if (!m0_mute) begin
          m0_hold <= m0_hlen;
          m0_xpn  <= m0_stuck ? m0_x : pwlcm(m0_x, m0_p);
        end
      end else begin
        m0_cnt <= m0_cnt - 1;
      end
    end
  end
  assign if0.map_done = (m0_hold > 0);
  assign if0.map_xpn  = m0_xpn;

  logic        m1_pend = 1'b0;
  int          m1_cnt = 0, m1_hold = 0;
  logic [31:0] m1_x = '0, m1_xpn = '0;
  logic [30:0] m1_p = '0;

  always @(posedge clk) begin
    if (m1_hold > 0) m1_hold <= m1_hold - 1;
    if (if1.map_start) begin
      m1_pend <= 1'b1;
      m1_cnt  <= L_MAP;
      m1_x    <= if1.map_xp;
      m1_p    <= if1.map_pp;
    end else if (m1_pend) begin
      if (m1_cnt == 1) begin
        m1_pend <= 1'b0;
        m1_hold <= 3;
        m1_xpn  <= pwlcm(m1_x, m1_p);
      end else begin
        m1_cnt <= m1_cnt - 1;
      end
    end
  end
  assign if1.map_done = (m1_hold > 0);
  assign if1.map_xpn  = m1_xpn;

  int st0 = 0, st1 = 0;
  always @(negedge clk) begin
    if (if0.map_start) st0++;
    if (if1.map_start) st1++;
  end

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs,
                        input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic cfg0(input logic [31:0] x0, input logic [30:0] p,
                      input logic [15:0] n);
    @(negedge clk);
    if0.cfg_valid  = 1'b1;
    if0.cfg_x0     = x0;
    if0.cfg_p      = p;
    if0.cfg_nwords = n;
    @(negedge clk);
    if0.cfg_valid = 1'b0;
  endtask

  task automatic wait_valid0(output logic ok);
    ok = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (if0.ks_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle0(input string tag);
    logic ok;
    ok = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (!if0.busy) begin ok = 1'b1; break; end
    end
    check1({tag, "_idle"}, ok, 1'b1);
  endtask

  task automatic run0(input string tag, input logic [31:0] x0,
                      input logic [30:0] p, input int n);
    logic [31:0] x;
    logic ok;
    int s;
    s = st0;
    cfg0(x0, p, 16'(n));
    x = x0;
    for (int i = 0; i < n; i++) begin
      x = pwlcm(x, p);
      wait_valid0(ok);
      check1($sformatf("%s_v%0d", tag, i), ok, 1'b1);
      check32($sformatf("%s_w%0d", tag, i), if0.ks_data, x);
    end
    wait_idle0(tag);
    check32({tag, "_starts"}, 32'(st0 - s), 32'(n));
  endtask

  initial begin
    logic [31:0] x, d, rx;
    logic [30:0] rp;
    logic ok, stable, saw_d, saw_v;
    int s;

    if0.cfg_valid = 1'b0; if0.cfg_x0 = '0; if0.cfg_p = '0;
    if0.cfg_nwords = '0; if0.ks_ready = 1'b1;
    if1.cfg_valid = 1'b0; if1.cfg_x0 = '0; if1.cfg_p = '0;
    if1.cfg_nwords = '0; if1.ks_ready = 1'b1;

    // reset state
    @(negedge clk);
    check32("rst_xp", if0.map_xp, 32'h0);
    check32("rst_pp", 32'(if0.map_pp), 32'h0);
    check32("rst_ks", if0.ks_data, 32'h0);
    check1("rst_start", if0.map_start, 1'b0);
    check1("rst_valid", if0.ks_valid, 1'b0);
    check1("rst_busy", if0.busy, 1'b0);
    check1("rst_ecfg", if0.err_cfg, 1'b0);
    check1("rst_etmo", if0.err_timeout, 1'b0);
    check1("rst_estk", if0.err_stuck, 1'b0);
    check1("rst_ready", if0.cfg_ready, 1'b1);
    rst = 1'b0;

    // seeded run, no warm-up
    run0("t1", 32'h8000_0097, 31'd2034, 4);
    check32("t1_pp", 32'(if0.map_pp), 32'd2034);

    // warm-up of 64 on the second instance
    s = st1;
    @(negedge clk);
    if1.cfg_valid = 1'b1; if1.cfg_x0 = 32'h8000_0097;
    if1.cfg_p = 31'd2034; if1.cfg_nwords = 16'd1;
    @(negedge clk);
    if1.cfg_valid = 1'b0;
    x = 32'h8000_0097;
    for (int i = 0; i < 65; i++) x = pwlcm(x, 31'd2034);
    ok = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (if1.ks_valid) begin ok = 1'b1; break; end
    end
    check1("t2_valid", ok, 1'b1);
    check32("t2_x65", if1.ks_data, x);
    repeat (3) @(negedge clk);
    check32("t2_starts", 32'(st1 - s), 32'd65);
    check1("t2_idle", if1.busy, 1'b0);

    // downstream stall in EMIT
    if0.ks_ready = 1'b0;
    rx = 32'h1234_5678; rp = 31'h0ABC_DEF1;
    cfg0(rx, rp, 16'd2);
    x = pwlcm(rx, rp);
    wait_valid0(ok);
    check1("t3_v0", ok, 1'b1);
    d = if0.ks_data;
    s = st0;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!if0.ks_valid || if0.ks_data !== d) stable = 1'b0;
    end
    check1("t3_stable", stable, 1'b1);
    check32("t3_nostart", 32'(st0 - s), 32'd0);
    check32("t3_w0", d, x);
    if0.ks_ready = 1'b1;
    x = pwlcm(x, rp);
    wait_valid0(ok);
    check1("t3_v1", ok, 1'b1);
    check32("t3_w1", if0.ks_data, x);
    wait_idle0("t3");

    // map core never answers
    m0_mute = 1'b1;
    cfg0(32'h4000_0001, 31'h1000_0000, 16'd1);
    ok = 1'b0;
    repeat (10) begin
      if (if0.map_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check1("t4_start", ok, 1'b1);
    repeat (TMO) @(negedge clk);
    check1("t4_pre_err", if0.err_timeout, 1'b0);
    check1("t4_pre_busy", if0.busy, 1'b1);
    @(negedge clk);
    check1("t4_err", if0.err_timeout, 1'b1);
    check1("t4_idle", if0.cfg_ready, 1'b1);
    m0_mute = 1'b0;
    repeat (50) @(negedge clk);

    // stale done level spans START and the blanking window
    m0_hlen = 6;
    run0("t5", 32'h9E37_79B9, 31'h2545_F491, 2);
    check1("t5_nostuck", if0.err_stuck, 1'b0);
    check1("t5_notmo", if0.err_timeout, 1'b0);
    m0_hlen = 3;
    repeat (10) @(negedge clk);

    // rejected seeds
    s = st0;
    cfg0(32'h0, 31'd77, 16'd3);
    check1("t6_ecfg_x", if0.err_cfg, 1'b1);
    cfg0(32'h5555_0000, 31'd0, 16'd3);
    check1("t6_ecfg_p", if0.err_cfg, 1'b1);
    repeat (5) @(negedge clk);
    check32("t6_nostart", 32'(st0 - s), 32'd0);
    check1("t6_busy", if0.busy, 1'b0);

    // fixed point
    m0_stuck = 1'b1;
    cfg0(32'h2222_3333, 31'h0100_0000, 16'd2);
    check1("t6_ecfg_clr", if0.err_cfg, 1'b0);
    wait_idle0("t6s");
    check1("t6_stuck", if0.err_stuck, 1'b1);
    check1("t6_s_val", if0.ks_valid, 1'b0);
    m0_stuck = 1'b0;

    // reset while waiting for the map core
    cfg0(32'h7654_3210, 31'h0321_0000, 16'd1);
    check1("t6_estk_clr", if0.err_stuck, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("t6_r_busy", if0.busy, 1'b0);
    check32("t6_r_xp", if0.map_xp, 32'h0);
    saw_d = 1'b0; saw_v = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (if0.map_done) saw_d = 1'b1;
      if (if0.ks_valid) saw_v = 1'b1;
    end
    check1("t6_r_done", saw_d, 1'b1);
    check1("t6_r_noval", saw_v, 1'b0);
    check1("t6_r_idle", if0.busy, 1'b0);

    // randomized seeds
    for (int k = 0; k < 5; k++) begin
      rx = $urandom;
      if (rx == 0) rx = 32'h1;
      rp = 31'($urandom_range(1, 32'h7FFF_FFFF));
      run0($sformatf("r%0d", k), rx, rp,
           int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
